// File: rtl/bus_host_initiator.sv
// Host-side initiator for the 24-bit register bus: queues byte read/write commands and
// runs one bus transaction per grant, returning read data on a valid/ready channel.
module bus_host_initiator #(
    parameter int FIFO_DEPTH = 4,
    parameter int HOLD_TICKS = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_ce,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [23:0] cmd_address,
    input  logic [7:0]  cmd_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [7:0]  rsp_data,
    output logic        bus_req,
    input  logic        bus_grant,
    output logic        bus_write,
    output logic        bus_read,
    output logic [23:0] bus_address_out,
    output logic [7:0]  bus_data_out,
    input  logic [7:0]  bus_data_in,
    output logic        busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

    typedef struct packed {
        logic        wr;
        logic [23:0] addr;
        logic [7:0]  dat;
    } cmd_t;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        ADDR,
        HOLD,
        RESP
    } state_t;

    cmd_t               fifo_mem_q [FIFO_DEPTH];
    cmd_t               fifo_mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]     count_q, count_d;

    state_t             state_q, state_d;
    cmd_t               txn_q, txn_d;
    logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic               bus_req_q, bus_req_d;
    logic               bus_write_q, bus_write_d;
    logic               bus_read_q, bus_read_d;
    logic [23:0]        addr_q, addr_d;
    logic [7:0]         dat_q, dat_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [7:0]         rsp_data_q, rsp_data_d;

    logic               push;
    logic               pop;

    // Ready depends only on registered occupancy, never on this cycle's pop.
    assign cmd_ready = (count_q != (PTR_W+1)'(FIFO_DEPTH)) && !reset;
    assign push      = cmd_valid && cmd_ready;

    always_comb begin
        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (push) begin
            fifo_mem_d[wr_ptr_q] = '{wr: cmd_write, addr: cmd_address, dat: cmd_data};
            wr_ptr_d             = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + (PTR_W+1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (PTR_W+1)'(1);
        end
    end

    always_comb begin
        state_d     = state_q;
        txn_d       = txn_q;
        hold_cnt_d  = hold_cnt_q;
        bus_req_d   = bus_req_q;
        bus_write_d = bus_write_q;
        bus_read_d  = bus_read_q;
        addr_d      = addr_q;
        dat_d       = dat_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        pop         = 1'b0;

        case (state_q)
            IDLE: begin
                if (clk_ce && (count_q != '0)) begin
                    pop     = 1'b1;
                    txn_d   = fifo_mem_q[rd_ptr_q];
                    state_d = REQ;
                end
            end
            REQ: begin
                if (clk_ce) begin
                    bus_req_d = 1'b1;
                    if (bus_grant) begin
                        bus_write_d = txn_q.wr;
                        bus_read_d  = !txn_q.wr;
                        addr_d      = txn_q.addr;
                        dat_d       = txn_q.dat;
                        state_d     = ADDR;
                    end
                end
            end
            ADDR: begin
                // Grant is no longer consulted: once on the bus the transaction completes.
                if (clk_ce) begin
                    if (!txn_q.wr) begin
                        rsp_data_d = bus_data_in;
                    end
                    bus_write_d = 1'b0;
                    bus_read_d  = 1'b0;
                    hold_cnt_d  = '0;
                    state_d     = HOLD;
                end
            end
            HOLD: begin
                if (clk_ce) begin
                    if (hold_cnt_q == CNT_W'(HOLD_TICKS - 1)) begin
                        bus_req_d = 1'b0;
                        addr_d    = '0;
                        dat_d     = '0;
                        if (txn_q.wr) begin
                            state_d = IDLE;
                        end else begin
                            rsp_valid_d = 1'b1;
                            state_d     = RESP;
                        end
                    end else begin
                        hold_cnt_d = hold_cnt_q + CNT_W'(1);
                    end
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fifo_mem_q  <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= IDLE;
            txn_q       <= '0;
            hold_cnt_q  <= '0;
            bus_req_q   <= 1'b0;
            bus_write_q <= 1'b0;
            bus_read_q  <= 1'b0;
            addr_q      <= '0;
            dat_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            fifo_mem_q  <= fifo_mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            txn_q       <= txn_d;
            hold_cnt_q  <= hold_cnt_d;
            bus_req_q   <= bus_req_d;
            bus_write_q <= bus_write_d;
            bus_read_q  <= bus_read_d;
            addr_q      <= addr_d;
            dat_q       <= dat_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign bus_req         = bus_req_q;
    assign bus_write       = bus_write_q;
    assign bus_read        = bus_read_q;
    assign bus_address_out = addr_q;
    assign bus_data_out    = dat_q;
    assign rsp_valid       = rsp_valid_q;
    assign rsp_data        = rsp_data_q;
    assign busy            = (count_q != '0) || (state_q != IDLE);

endmodule

// File: tb/tb_bus_host_initiator.sv
// Directed bench for bus_host_initiator with a latch-on-next-tick responder model
// and scoreboards for bus writes and read responses.
module tb_bus_host_initiator;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clk_ce = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [23:0] cmd_address = '0;
    logic [7:0]  cmd_data = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [7:0]  rsp_data;
    logic        bus_req;
    logic        bus_grant = 1'b0;
    logic        bus_write;
    logic        bus_read;
    logic [23:0] bus_address_out;
    logic [7:0]  bus_data_out;
    logic [7:0]  bus_data_in;
    logic        busy;

    always #5 clk = ~clk;

    bus_host_initiator #(.FIFO_DEPTH(4), .HOLD_TICKS(1)) dut (
        .clk             (clk),
        .reset           (reset),
        .clk_ce          (clk_ce),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_write       (cmd_write),
        .cmd_address     (cmd_address),
        .cmd_data        (cmd_data),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_data        (rsp_data),
        .bus_req         (bus_req),
        .bus_grant       (bus_grant),
        .bus_write       (bus_write),
        .bus_read        (bus_read),
        .bus_address_out (bus_address_out),
        .bus_data_out    (bus_data_out),
        .bus_data_in     (bus_data_in),
        .busy            (busy)
    );

    int          n_tests = 0;
    int          n_fail = 0;
    int          ce_div = 1;
    int          ce_cnt = 0;
    int          commits = 0;
    int          hi, act, c0;
    logic [7:0]  regs [3] = '{default: 8'h00};
    logic [7:0]  shadow [3] = '{default: 8'h00};
    logic        pend = 1'b0;
    logic [23:0] pa = '0;
    logic [7:0]  pd = '0;
    logic        bw_prev = 1'b0;
    logic [31:0] e_wr;
    logic [7:0]  e_rd;
    logic [31:0] exp_wr [$];
    logic [7:0]  exp_rd [$];

    function automatic int idx(input logic [23:0] a);
        if (a >= 24'h002000 && a <= 24'h002002) return int'(a - 24'h002000);
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Responder: bus_write sampled on one clk_ce tick, committed on the next.
    always_comb begin
        bus_data_in = 8'h00;
        if (idx(bus_address_out) >= 0) bus_data_in = regs[idx(bus_address_out)];
    end

    always @(posedge clk) begin
        if (reset) begin
            pend <= 1'b0;
        end else if (clk_ce) begin
            if (pend) begin
                commits <= commits + 1;
                if (idx(pa) >= 0) regs[idx(pa)] <= pd;
            end
            pend <= bus_write;
            pa   <= bus_address_out;
            pd   <= bus_data_out;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            bw_prev <= 1'b0;
        end else begin
            if (bus_write && !bw_prev) begin
                chk("wr_expected", 32'(exp_wr.size() != 0), 1);
                if (exp_wr.size() != 0) begin
                    e_wr = exp_wr.pop_front();
                    chk("wr_bus_addr_data", {bus_address_out, bus_data_out}, e_wr);
                end
            end
            bw_prev <= bus_write;
            if (rsp_valid && rsp_ready) begin
                chk("rsp_expected", 32'(exp_rd.size() != 0), 1);
                if (exp_rd.size() != 0) begin
                    e_rd = exp_rd.pop_front();
                    chk("rsp_data_sb", 32'(rsp_data), 32'(e_rd));
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            ce_cnt = (ce_cnt + 1) % 4;
            if (ce_div == 1) clk_ce = 1'b1;
            else if (ce_div == 4) clk_ce = (ce_cnt == 0);
            else clk_ce = 1'b0;
        end
    end

    task automatic push_cmd(input logic w, input logic [23:0] a, input logic [7:0] d);
        cmd_write   = w;
        cmd_address = a;
        cmd_data    = d;
        cmd_valid   = 1'b1;
        for (int i = 0; i < 200 && !cmd_ready; i++) step();
        chk("push_ready", 32'(cmd_ready), 1);
        if (w) begin
            exp_wr.push_back({a, d});
            if (idx(a) >= 0) shadow[idx(a)] = d;
        end else begin
            exp_rd.push_back((idx(a) >= 0) ? shadow[idx(a)] : 8'h00);
        end
        step();
        cmd_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        repeat (3) step();
        chk("rst_bus_req", 32'(bus_req), 0);
        chk("rst_bus_write", 32'(bus_write), 0);
        chk("rst_bus_read", 32'(bus_read), 0);
        chk("rst_addr", 32'(bus_address_out), 0);
        chk("rst_data", 32'(bus_data_out), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_data", 32'(rsp_data), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_cmd_ready", 32'(cmd_ready), 0);
        reset = 1'b0;
        bus_grant = 1'b1;
        step();
        chk("ready_after_rst", 32'(cmd_ready), 1);

        // Single write: pushed at edge 0, bus_write during edge 2..3, held one more cycle.
        c0 = commits;
        push_cmd(1'b1, 24'h002001, 8'hA5);
        chk("w1_write_e0", 32'(bus_write), 0);
        step();
        chk("w1_write_e1", 32'(bus_write), 0);
        step();
        chk("w1_req_e2", 32'(bus_req), 1);
        chk("w1_write_e2", 32'(bus_write), 1);
        chk("w1_read_e2", 32'(bus_read), 0);
        chk("w1_addr_e2", 32'(bus_address_out), 'h002001);
        chk("w1_data_e2", 32'(bus_data_out), 'hA5);
        step();
        chk("w1_write_e3", 32'(bus_write), 0);
        chk("w1_req_e3", 32'(bus_req), 1);
        chk("w1_addr_e3", 32'(bus_address_out), 'h002001);
        chk("w1_data_e3", 32'(bus_data_out), 'hA5);
        step();
        chk("w1_addr_e4", 32'(bus_address_out), 0);
        chk("w1_data_e4", 32'(bus_data_out), 0);
        step();
        chk("w1_busy_e5", 32'(busy), 0);
        chk("w1_commits", 32'(commits - c0), 1);
        chk("w1_reg2001", 32'(regs[1]), 'hA5);

        // Read-back with response backpressure.
        rsp_ready = 1'b0;
        push_cmd(1'b1, 24'h002002, 8'h3C);
        push_cmd(1'b0, 24'h002002, 8'h00);
        for (int i = 0; i < 100 && !rsp_valid; i++) step();
        chk("rb_valid", 32'(rsp_valid), 1);
        chk("rb_data", 32'(rsp_data), 'h3C);
        chk("rb_req_in_resp", 32'(bus_req), 0);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("rb_valid_hold", 32'(rsp_valid), 1);
            chk("rb_data_hold", 32'(rsp_data), 'h3C);
        end
        rsp_ready = 1'b1;
        step();
        chk("rb_valid_drop", 32'(rsp_valid), 0);
        step();
        chk("rb_busy_end", 32'(busy), 0);

        // Backpressure with clk_ce stopped, then a grant stall.
        bus_grant = 1'b0;
        ce_div = 0;
        step();
        step();
        push_cmd(1'b1, 24'h002000, 8'h11);
        push_cmd(1'b0, 24'h002000, 8'h00);
        push_cmd(1'b1, 24'h000123, 8'h77);
        push_cmd(1'b0, 24'h000123, 8'h00);
        chk("bp_full_ready", 32'(cmd_ready), 0);
        chk("bp_busy", 32'(busy), 1);
        chk("bp_no_req", 32'(bus_req), 0);
        ce_div = 1;
        push_cmd(1'b1, 24'h002001, 8'h5A);
        step();
        step();
        for (int k = 0; k < 10; k++) begin
            chk("stall_req", 32'(bus_req), 1);
            chk("stall_write", 32'(bus_write), 0);
            step();
        end
        bus_grant = 1'b1;
        step();
        chk("grant_write", 32'(bus_write), 1);
        chk("grant_addr", 32'(bus_address_out), 'h002000);
        for (int i = 0; i < 500 && busy; i++) step();
        chk("bp_busy_end", 32'(busy), 0);
        chk("bp_wr_drained", 32'(exp_wr.size()), 0);
        chk("bp_rd_drained", 32'(exp_rd.size()), 0);
        chk("bp_reg2000", 32'(regs[0]), 'h11);
        chk("bp_reg2001", 32'(regs[1]), 'h5A);

        // Sparse clk_ce: one tick in four.
        ce_div = 4;
        c0 = commits;
        hi = 0;
        push_cmd(1'b1, 24'h002000, 8'hC3);
        for (int i = 0; i < 200 && busy; i++) begin
            if (bus_write) hi++;
            step();
        end
        chk("sp_busy_end", 32'(busy), 0);
        chk("sp_write_cycles", 32'(hi), 4);
        repeat (8) step();
        chk("sp_commits", 32'(commits - c0), 1);
        chk("sp_reg2000", 32'(regs[0]), 'hC3);

        // Reset while a write is in ADDR with two more queued.
        ce_div = 0;
        bus_grant = 1'b1;
        step();
        step();
        push_cmd(1'b1, 24'h002001, 8'hE7);
        push_cmd(1'b1, 24'h002002, 8'h99);
        push_cmd(1'b1, 24'h002000, 8'h42);
        ce_div = 1;
        for (int i = 0; i < 100 && !bus_write; i++) step();
        chk("rm_in_addr", 32'(bus_write), 1);
        c0 = commits;
        reset = 1'b1;
        step();
        chk("rm_bus_write", 32'(bus_write), 0);
        chk("rm_bus_req", 32'(bus_req), 0);
        chk("rm_rsp_valid", 32'(rsp_valid), 0);
        chk("rm_addr", 32'(bus_address_out), 0);
        chk("rm_data", 32'(bus_data_out), 0);
        chk("rm_busy", 32'(busy), 0);
        chk("rm_ready_in_rst", 32'(cmd_ready), 0);
        reset = 1'b0;
        exp_wr.delete();
        step();
        chk("rm_ready_after", 32'(cmd_ready), 1);
        act = 0;
        for (int k = 0; k < 20; k++) begin
            if (bus_write || bus_read || bus_req || rsp_valid || busy) act++;
            step();
        end
        chk("rm_no_activity", 32'(act), 0);
        chk("rm_no_commit", 32'(commits - c0), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
